// File: rtl/ram_seq_pkg.sv
// Shared types and default widths for the RAM sequencing controller.
package ram_seq_pkg;

    localparam int ADR_W_DEF  = 16;
    localparam int DATA_W_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_DUMP_ADR = 3'd2,
        ST_DUMP_OUT = 3'd3,
        ST_DONE     = 3'd4
    } ram_seq_state_t;

endpackage

// File: rtl/ram_seq_addr_cnt.sv
// Loadable address counter (wraps modulo 2^ADR_W) paired with a
// remaining-word down-counter. Shared by the LOAD and DUMP paths.
module ram_seq_addr_cnt
    import ram_seq_pkg::*;
#(
    parameter int ADR_W = ADR_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [ADR_W-1:0] base,
    input  logic [ADR_W-1:0] len,
    output logic [ADR_W-1:0] addr,
    output logic [ADR_W-1:0] addr_nxt,
    output logic             rem_zero,
    output logic             rem_last
);

    logic [ADR_W-1:0] rem;

    assign addr_nxt = addr + ADR_W'(1);
    assign rem_zero = (rem == '0);
    assign rem_last = (rem == ADR_W'(1));

    // Capture base/len on load; advance address and consume one word on step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
            rem  <= '0;
        end else if (load) begin
            addr <= base;
            rem  <= len;
        end else if (step) begin
            addr <= addr_nxt;
            rem  <= rem - ADR_W'(1);
        end
    end

endmodule

// File: rtl/ram_seq_ctrl.sv
// Sequencing controller in front of a single-port RAM: streams words in
// (LOAD) or out (DUMP) over valid/ready, starting at a captured base address.
// Optional build macro RAM_SEQ_CHECKSUM_EN adds an XOR checksum output.
//
// state       | meaning
// ------------+-------------------------------------------------------
// ST_IDLE     | waiting for start_load / start_dump
// ST_LOAD     | accepting s_data, one RAM write the cycle after each accept
// ST_DUMP_ADR | ram_adr presented, RAM output settling
// ST_DUMP_OUT | m_data held valid until consumer takes it
// ST_DONE     | one-cycle done pulse, then back to idle
module ram_seq_ctrl
    import ram_seq_pkg::*;
#(
    parameter int ADR_W  = ADR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_load,
    input  logic              start_dump,
    input  logic [ADR_W-1:0]  base_adr,
    input  logic [ADR_W-1:0]  len,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic [ADR_W-1:0]  ram_adr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy,
    output logic              done
`ifdef RAM_SEQ_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    ram_seq_state_t    state, state_d;
    logic [ADR_W-1:0]  ram_adr_d;
    logic              ram_we_d;
    logic [DATA_W-1:0] ram_din_d;
    logic              s_ready_d;
    logic              m_valid_d;
    logic [DATA_W-1:0] m_data_d;
    logic              cnt_load;
    logic              cnt_step;
    logic [ADR_W-1:0]  addr;
    logic [ADR_W-1:0]  addr_nxt;
    logic              rem_zero;
    logic              rem_last;
    logic              s_accept;
    logic              m_accept;

    assign s_accept = (state == ST_LOAD) && s_valid && s_ready;
    assign m_accept = (state == ST_DUMP_OUT) && m_valid && m_ready;

    ram_seq_addr_cnt #(.ADR_W(ADR_W)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .step     (cnt_step),
        .base     (base_adr),
        .len      (len),
        .addr     (addr),
        .addr_nxt (addr_nxt),
        .rem_zero (rem_zero),
        .rem_last (rem_last)
    );

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        state_d   = state;
        ram_adr_d = ram_adr;
        ram_we_d  = 1'b0;
        ram_din_d = ram_din;
        s_ready_d = 1'b0;
        m_valid_d = m_valid;
        m_data_d  = m_data;
        cnt_load  = 1'b0;
        cnt_step  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_load || start_dump) begin
                    cnt_load = 1'b1;
                    if (len == '0) begin
                        state_d = ST_DONE;
                    end else if (start_load) begin
                        state_d   = ST_LOAD;
                        s_ready_d = 1'b1;
                    end else begin
                        state_d   = ST_DUMP_ADR;
                        ram_adr_d = base_adr;
                    end
                end
            end
            ST_LOAD: begin
                if (s_accept) begin
                    ram_we_d  = 1'b1;
                    ram_din_d = s_data;
                    ram_adr_d = addr;
                    cnt_step  = 1'b1;
                    s_ready_d = !rem_last;
                end else if (rem_zero) begin
                    // last write has just been issued; close out
                    state_d = ST_DONE;
                end else begin
                    s_ready_d = 1'b1;
                end
            end
            ST_DUMP_ADR: begin
                m_data_d  = ram_dout;
                m_valid_d = 1'b1;
                state_d   = ST_DUMP_OUT;
            end
            ST_DUMP_OUT: begin
                if (m_accept) begin
                    m_valid_d = 1'b0;
                    cnt_step  = 1'b1;
                    if (rem_last) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d   = ST_DUMP_ADR;
                        ram_adr_d = addr_nxt;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; busy/done decode from the next state so they stay registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            ram_adr <= '0;
            ram_we  <= 1'b0;
            ram_din <= '0;
            s_ready <= 1'b0;
            m_valid <= 1'b0;
            m_data  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_d;
            ram_adr <= ram_adr_d;
            ram_we  <= ram_we_d;
            ram_din <= ram_din_d;
            s_ready <= s_ready_d;
            m_valid <= m_valid_d;
            m_data  <= m_data_d;
            busy    <= (state_d == ST_LOAD) || (state_d == ST_DUMP_ADR) ||
                       (state_d == ST_DUMP_OUT);
            done    <= (state_d == ST_DONE);
        end
    end

`ifdef RAM_SEQ_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_d;

    // Running XOR of every word accepted in LOAD or handed off in DUMP.
    always_comb begin
        checksum_d = checksum;
        if (cnt_load) begin
            checksum_d = '0;
        end else if (s_accept) begin
            checksum_d = checksum ^ s_data;
        end else if (m_accept) begin
            checksum_d = checksum ^ m_data;
        end
    end

    // Checksum register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum <= '0;
        end else begin
            checksum <= checksum_d;
        end
    end
`endif

endmodule

// File: tb/tb_ram_seq_ctrl.sv
// Self-checking bench for ram_seq_ctrl with a behavioural RAM and a
// reference memory image maintained from the words the bench loads.
module tb_ram_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start_load;
    logic        start_dump;
    logic [15:0] base_adr;
    logic [15:0] len;
    logic        s_valid;
    logic [3:0]  s_data;
    logic        s_ready;
    logic        m_valid;
    logic [3:0]  m_data;
    logic        m_ready;
    logic [15:0] ram_adr;
    logic        ram_we;
    logic [3:0]  ram_din;
    logic [3:0]  ram_dout;
    logic        busy;
    logic        done;
`ifdef RAM_SEQ_CHECKSUM_EN
    logic [3:0]  checksum;
`endif

    ram_seq_ctrl #(.ADR_W(16), .DATA_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_load (start_load),
        .start_dump (start_dump),
        .base_adr   (base_adr),
        .len        (len),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready),
        .ram_adr    (ram_adr),
        .ram_we     (ram_we),
        .ram_din    (ram_din),
        .ram_dout   (ram_dout),
        .busy       (busy),
        .done       (done)
`ifdef RAM_SEQ_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  mem     [0:65535];
    logic [3:0]  ref_mem [0:65535];
    logic [19:0] wr_q[$];
    int          done_cnt;
    logic [3:0]  src_q[$];
    int          total;
    int          bad;

    assign ram_dout = mem[ram_adr];

    // Behavioural RAM: synchronous write, logs every write it performs.
    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 4'h0;
        forever begin
            @(posedge clk);
            if (ram_we === 1'b1) begin
                mem[ram_adr] = ram_din;
                wr_q.push_back({ram_adr, ram_din});
            end
        end
    end

    initial begin
        done_cnt = 0;
        forever begin
            @(posedge clk);
            if (done === 1'b1) done_cnt++;
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; start_load = 1'b0; start_dump = 1'b0; base_adr = '0; len = '0;
        s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({ram_adr, ram_we, ram_din, s_ready, m_valid, m_data, busy, done} !== 30'h0) begin
            bad++;
            $display("FAIL reset_vals got=%h exp=0",
                     {ram_adr, ram_we, ram_din, s_ready, m_valid, m_data, busy, done});
        end
`ifdef RAM_SEQ_CHECKSUM_EN
        total++;
        if (checksum !== 4'h0) begin bad++; $display("FAIL reset_chk got=%h exp=0", checksum); end
`endif
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({busy, done, s_ready, m_valid, ram_we} !== 5'b0) begin
            bad++; $display("FAIL idle_after_reset got=%b exp=00000", {busy, done, s_ready, m_valid, ram_we});
        end
    endtask

    // Load src_q at base; expected writes/checksum come from src_q only.
    task automatic run_load(input logic [15:0] base, input bit gaps, input bit both);
        int n, idx, cyc, wb, db;
        bit acc, mv_bad;
        logic [3:0] x;
        n = src_q.size(); idx = 0; cyc = 0; mv_bad = 0; x = 4'h0;
        wb = wr_q.size(); db = done_cnt;
        foreach (src_q[i]) x ^= src_q[i];
        @(negedge clk);
        start_load = 1'b1; start_dump = both; base_adr = base; len = 16'(n);
        @(negedge clk);
        start_load = 1'b0; start_dump = 1'b0; base_adr = 16'($urandom); len = 16'($urandom);
        total++;
        if ({s_ready, m_valid, busy} !== 3'b101) begin
            bad++; $display("FAIL load_entry got=%b exp=101", {s_ready, m_valid, busy});
        end
        while (idx < n && cyc < 400) begin
            s_valid    = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data     = s_valid ? src_q[idx] : 4'($urandom);
            start_dump = gaps ? ($urandom_range(0, 3) == 0) : 1'b0;
            acc = s_valid && (s_ready === 1'b1);
            if (m_valid !== 1'b0) mv_bad = 1;
            @(negedge clk);
            cyc++;
            if (acc) begin
                total++;
                if ({ram_we, ram_adr, ram_din} !== {1'b1, base + 16'(idx), src_q[idx]}) begin
                    bad++;
                    $display("FAIL write_timing got=%h exp=%h", {ram_we, ram_adr, ram_din},
                             {1'b1, base + 16'(idx), src_q[idx]});
                end
                idx++;
            end
        end
        s_valid = 1'b0; start_dump = 1'b0;
        if (idx < n) begin bad++; total++; $display("FAIL load_timeout got=%0d exp=%0d", idx, n); end
        total++;
        if (s_ready !== 1'b0) begin bad++; $display("FAIL ready_after_last got=%b exp=0", s_ready); end
        @(negedge clk);
        total++;
        if ({done, busy, ram_we} !== 3'b100) begin
            bad++; $display("FAIL load_done got=%b exp=100", {done, busy, ram_we});
        end
`ifdef RAM_SEQ_CHECKSUM_EN
        total++;
        if (checksum !== x) begin bad++; $display("FAIL load_chk got=%h exp=%h", checksum, x); end
`endif
        @(negedge clk);
        total++;
        if ({done, busy} !== 2'b00) begin bad++; $display("FAIL done_single got=%b exp=00", {done, busy}); end
        total++;
        if (done_cnt - db !== 1) begin bad++; $display("FAIL load_done_cnt got=%0d exp=1", done_cnt - db); end
        total++;
        if (wr_q.size() - wb !== n) begin bad++; $display("FAIL write_count got=%0d exp=%0d", wr_q.size() - wb, n); end
        for (int i = 0; i < n && wb + i < wr_q.size(); i++) begin
            total++;
            if (wr_q[wb + i] !== {base + 16'(i), src_q[i]}) begin
                bad++; $display("FAIL write_log got=%h exp=%h", wr_q[wb + i], {base + 16'(i), src_q[i]});
            end
            total++;
            if (mem[base + 16'(i)] !== src_q[i]) begin
                bad++; $display("FAIL ram_read got=%h exp=%h", mem[base + 16'(i)], src_q[i]);
            end
            ref_mem[base + 16'(i)] = src_q[i];
        end
        total++;
        if (mv_bad) begin bad++; $display("FAIL m_valid_in_load got=1 exp=0"); end
    endtask

    // mode 0: m_ready always high; 1: random m_ready; 2: first word held off 5 cycles.
    task automatic run_dump(input logic [15:0] base, input int n, input int mode);
        int idx, cyc, last, bp_left, stall_cnt, db;
        bit stall, sr_bad;
        logic [3:0] held_d, x, e;
        logic [15:0] held_a;
        idx = 0; cyc = 0; last = 0; stall = 0; sr_bad = 0; stall_cnt = 0; x = 4'h0;
        bp_left = (mode == 2) ? 5 : 0; db = done_cnt; held_d = '0; held_a = '0;
        @(negedge clk);
        start_dump = 1'b1; base_adr = base; len = 16'(n); m_ready = 1'b0;
        @(negedge clk);
        start_dump = 1'b0; base_adr = 16'($urandom); len = 16'($urandom);
        while (idx < n && cyc < 1000) begin
            if (stall) begin
                total++;
                if ({m_valid, m_data, ram_adr} !== {1'b1, held_d, held_a}) begin
                    bad++; $display("FAIL backpressure_hold got=%h exp=%h",
                                    {m_valid, m_data, ram_adr}, {1'b1, held_d, held_a});
                end
            end
            if (mode == 0) m_ready = 1'b1;
            else if (mode == 1) m_ready = 1'($urandom_range(0, 1));
            else m_ready = !(m_valid === 1'b1 && bp_left > 0);
            if (mode == 2 && m_valid === 1'b1 && bp_left > 0) bp_left--;
            stall = (m_valid === 1'b1) && !m_ready;
            if (stall) stall_cnt++;
            held_d = m_data; held_a = ram_adr;
            if (m_valid === 1'b1 && m_ready) begin
                e = ref_mem[base + 16'(idx)];
                x ^= e;
                total++;
                if (m_data !== e) begin bad++; $display("FAIL dump_data got=%h exp=%h", m_data, e); end
                if (mode == 0 && idx > 0) begin
                    total++;
                    if (cyc - last !== 2) begin bad++; $display("FAIL dump_rate got=%0d exp=2", cyc - last); end
                end
                last = cyc;
                idx++;
            end
            if (s_ready !== 1'b0) sr_bad = 1;
            @(negedge clk);
            cyc++;
        end
        m_ready = 1'b0;
        if (idx < n) begin bad++; total++; $display("FAIL dump_timeout got=%0d exp=%0d", idx, n); end
        total++;
        if ({done, busy, m_valid} !== 3'b100) begin
            bad++; $display("FAIL dump_done got=%b exp=100", {done, busy, m_valid});
        end
`ifdef RAM_SEQ_CHECKSUM_EN
        total++;
        if (checksum !== x) begin bad++; $display("FAIL dump_chk got=%h exp=%h", checksum, x); end
`endif
        @(negedge clk);
        total++;
        if (done_cnt - db !== 1 || done !== 1'b0) begin
            bad++; $display("FAIL dump_done_cnt got=%0d exp=1", done_cnt - db);
        end
        total++;
        if (sr_bad) begin bad++; $display("FAIL s_ready_in_dump got=1 exp=0"); end
        if (mode == 2) begin
            total++;
            if (stall_cnt !== 5) begin bad++; $display("FAIL stall_cycles got=%0d exp=5", stall_cnt); end
        end
    endtask

    task automatic test_write_basic();
        src_q = '{4'h3, 4'hA, 4'hF};
        run_load(16'h0000, 1'b0, 1'b0);
    endtask

    task automatic test_read_basic();
        run_dump(16'h0000, 3, 0);
    endtask

    task automatic test_read_backpressure();
        run_dump(16'h0000, 2, 2);
    endtask

    task automatic test_wrap();
        src_q = '{4'h7, 4'h9};
        run_load(16'hFFFF, 1'b0, 1'b0);
        run_dump(16'hFFFF, 2, 1);
    endtask

    task automatic test_zero_len();
        int wb;
        for (int k = 0; k < 2; k++) begin
            wb = wr_q.size();
            @(negedge clk);
            start_load = (k == 0); start_dump = (k == 1); base_adr = 16'h0040; len = 16'h0;
            @(negedge clk);
            start_load = 1'b0; start_dump = 1'b0;
            total++;
            if ({done, busy, s_ready, m_valid} !== 4'b1000) begin
                bad++; $display("FAIL zero_len_done got=%b exp=1000", {done, busy, s_ready, m_valid});
            end
            repeat (2) @(negedge clk);
            total++;
            if (wr_q.size() !== wb || done !== 1'b0) begin
                bad++; $display("FAIL zero_len_writes got=%0d exp=0", wr_q.size() - wb);
            end
        end
    endtask

    task automatic test_reset_mid();
        int wb;
        logic [3:0] d0, d1;
        d0 = 4'h5; d1 = 4'hC; wb = wr_q.size();
        @(negedge clk);
        start_load = 1'b1; base_adr = 16'h1230; len = 16'd3;
        @(negedge clk);
        start_load = 1'b0; s_valid = 1'b1; s_data = d0;
        @(negedge clk);
        s_data = d1;
        @(negedge clk);
        s_valid = 1'b0;
        total++;
        if ({ram_we, ram_adr, ram_din} !== {1'b1, 16'h1231, d1}) begin
            bad++; $display("FAIL pre_reset_write got=%h exp=%h", {ram_we, ram_adr, ram_din}, {1'b1, 16'h1231, d1});
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({ram_adr, ram_we, ram_din, s_ready, m_valid, m_data, busy, done} !== 30'h0) begin
            bad++;
            $display("FAIL reset_mid got=%h exp=0",
                     {ram_adr, ram_we, ram_din, s_ready, m_valid, m_data, busy, done});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (wr_q.size() - wb !== 1 || mem[16'h1230] !== d0 || mem[16'h1231] !== ref_mem[16'h1231]) begin
            bad++; $display("FAIL partial_write got=%0d exp=1", wr_q.size() - wb);
        end
        ref_mem[16'h1230] = d0;
        total++;
        if ({busy, s_ready, m_valid, done} !== 4'b0) begin
            bad++; $display("FAIL idle_after_mid_reset got=%b exp=0000", {busy, s_ready, m_valid, done});
        end
    endtask

    task automatic test_collision();
        src_q = '{4'h1, 4'hE};
        run_load(16'h0200, 1'b0, 1'b1);
        run_dump(16'h0200, 2, 0);
    endtask

    task automatic test_random();
        logic [15:0] base;
        int n;
        for (int k = 0; k < 8; k++) begin
            base = (k % 2 == 1) ? 16'hFFFF - 16'($urandom_range(0, 3)) : 16'($urandom);
            n = $urandom_range(1, 6);
            src_q.delete();
            for (int i = 0; i < n; i++) src_q.push_back(4'($urandom));
            run_load(base, 1'b1, 1'b0);
            run_dump(base, n, $urandom_range(0, 2));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; bad = 0;
        for (int i = 0; i < 65536; i++) ref_mem[i] = 4'h0;
        test_reset();
        test_write_basic();
        test_read_basic();
        test_read_backpressure();
        test_wrap();
        test_zero_len();
        test_reset_mid();
        test_collision();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
